tlin_dt: RTL and testbench

Discrete-time, multi-channel successor to the lumped lossless line `TLIN`. Each channel holds a circular sample buffer with a run-time delay of `D` samples and a signed attenuation factor. It sits in the sampled-data co-simulation path between the analog-to-sample bridge and downstream DSP models. It generalises the single ideal line in four ways: `N_CH` lines, configurable depth, loss, and streaming valid/ready flow control.

---
 rtl/tlin_dt_pkg.sv | 39 +++
 rtl/tlin_dt_lane.sv | 14 +
 rtl/tlin_dt.sv | 124 ++++++++++++
 tb/tb_tlin_dt.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tlin_dt_pkg.sv
// Shared types and arithmetic for the discrete-time multi-channel delay line.
package tlin_dt_pkg;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    // Widest sample/coefficient width the helper arithmetic supports.
    localparam int unsigned QW_MAX = 32;
    localparam int unsigned ACC_W  = 2 * QW_MAX;

    // Largest positive Q1.(w-1) value. Callers shift it right to their own width.
    localparam logic [QW_MAX-1:0] ALPHA_UNITY = 32'h7FFF_FFFF;

    // Q1.(w-1) multiply, round half up, saturate to w bits.
    // Operands must be sign-extended from w bits to QW_MAX bits.
    function automatic logic signed [QW_MAX-1:0] q_mul_rnd_sat(
        input logic signed [QW_MAX-1:0] x,
        input logic signed [QW_MAX-1:0] a,
        input int unsigned              w
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        acc = ACC_W'(x) * ACC_W'(a);
        acc = acc + (ACC_W'(1) <<< (w - 2));
        acc = acc >>> (w - 1);
        hi  = (ACC_W'(1) <<< (w - 1)) - ACC_W'(1);
        lo  = -hi - ACC_W'(1);
        if (acc > hi) begin
            acc = hi;
        end else if (acc < lo) begin
            acc = lo;
        end
        return acc[QW_MAX-1:0];
    endfunction

endpackage

// File: rtl/tlin_dt_lane.sv
// One channel's gain stage: multiply by alpha, round, saturate.
module tlin_dt_lane
    import tlin_dt_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = W'(q_mul_rnd_sat(QW_MAX'(signed'(x)), QW_MAX'(signed'(a)), W));

endmodule

// File: rtl/tlin_dt.sv
// Multi-channel discrete-time lossy delay line with valid/ready streaming.
module tlin_dt
    import tlin_dt_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned DEF_DELAY = 1,
    parameter int unsigned AW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [AW-1:0]     cfg_delay,
    input  logic [W-1:0]      cfg_alpha,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic              primed
);

    localparam int unsigned         PW        = $clog2(DEPTH);
    localparam int unsigned         VW        = N_CH * W;
    localparam logic [AW-1:0]       DEPTH_A   = AW'(DEPTH);
    localparam logic [PW-1:0]       PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [W-1:0]        ALPHA_RST = W'(ALPHA_UNITY >> (QW_MAX - W));

    logic [VW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_idx;
    logic [AW-1:0] fill_cnt;
    logic [AW-1:0] d_q;
    logic [AW-1:0] d_clamped;
    logic [W-1:0]  alpha_q;
    logic [VW-1:0] rd_vec;
    logic [VW-1:0] lane_out;
    logic [VW-1:0] out_next;
    logic          accept;
    state_t        state_q;
    state_t        state_d;

    // Read tap sits D entries behind the write pointer; with D == DEPTH it
    // lands on wr_ptr itself and the async read sees the value being replaced.
    assign rd_idx = PW'((AW'(wr_ptr) >= d_q) ? (AW'(wr_ptr) - d_q)
                                             : (AW'(wr_ptr) + (DEPTH_A - d_q)));
    assign rd_vec = mem[rd_idx];

    assign d_clamped = (cfg_delay == '0)     ? AW'(1)  :
                       (cfg_delay > DEPTH_A) ? DEPTH_A : cfg_delay;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        tlin_dt_lane #(.W(W)) u_lane (
            .x (rd_vec[c*W +: W]),
            .a (alpha_q),
            .y (lane_out[c*W +: W])
        );
    end

    // Handshake, output selection and FILL/RUN next state.
    always_comb begin
        state_d  = state_q;
        in_ready = !cfg_load && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        out_next = (state_q == RUN) ? lane_out : '0;
        if (cfg_load) begin
            state_d = FILL;
        end else if (accept && (state_q == FILL) && ((fill_cnt + AW'(1)) == d_q)) begin
            state_d = RUN;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample storage; contents survive flushes and are masked by FILL.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Configuration, pointers, fill count and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q       <= AW'(DEF_DELAY);
            alpha_q   <= ALPHA_RST;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (cfg_load) begin
            d_q       <= d_clamped;
            alpha_q   <= cfg_alpha;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (accept) begin
            wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (fill_cnt != d_q) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            out_valid <= 1'b1;
            out_data  <= out_next;
            if (state_q == RUN) begin
                primed <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlin_dt.sv
// Directed self-checking bench for tlin_dt (W=16, N_CH=2, DEPTH=64).
module tb_tlin_dt;

    localparam int unsigned W     = 16;
    localparam int unsigned N_CH  = 2;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic [AW-1:0]     cfg_delay;
    logic [W-1:0]      cfg_alpha;
    logic              in_valid;
    logic              in_ready;
    logic [N_CH*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_CH*W-1:0] out_data;
    logic              primed;

    int n_chk = 0;
    int n_err = 0;

    tlin_dt #(.W(W), .N_CH(N_CH), .DEPTH(DEPTH), .DEF_DELAY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .cfg_alpha (cfg_alpha),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one vector on channel ch and check the registered output.
    task automatic push(input int ch, input logic [15:0] v, input logic [15:0] e, input string tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = '0;
        in_data[ch*16 +: 16] = v;
        step();
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data[ch*16 +: 16]), 32'(e));
    endtask

    // Load configuration with a competing input that must be dropped.
    task automatic cfg(input logic [AW-1:0] d, input logic [15:0] a);
        cfg_load  = 1'b1;
        cfg_delay = d;
        cfg_alpha = a;
        in_valid  = 1'b1;
        in_data   = 32'h0BAD_0BAD;
        #1;
        chk("cfg_rdy", 32'(in_ready), 32'd0);
        step();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        chk("cfg_ov", 32'(out_valid), 32'd0);
        chk("cfg_primed", 32'(primed), 32'd0);
    endtask

    function automatic logic [15:0] rnd16();
        int v;
        v = int'($urandom_range(0, 32000)) - 16000;
        return v[15:0];
    endfunction

    initial begin
        logic [31:0] in_q[$];
        logic [31:0] exp_v;
        int sent;
        int got;

        rst = 1'b1; cfg_load = 1'b0; cfg_delay = '0; cfg_alpha = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", out_data, 32'd0);
        chk("rst_primed", 32'(primed), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Default D=1, alpha=0x7FFF
        push(0, 16'd100, 16'd0, "d1_0");
        chk("d1_primed0", 32'(primed), 32'd0);
        push(0, 16'd200, 16'd100, "d1_1");
        chk("d1_primed1", 32'(primed), 32'd1);
        push(0, 16'd300, 16'd200, "d1_2");
        in_valid = 1'b0;

        // D=4, alpha=0.5, ramp on channel 1
        cfg(7'd4, 16'h4000);
        begin
            logic [15:0] ramp_exp [10];
            ramp_exp = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
            for (int i = 0; i < 10; i++) begin
                push(1, 16'(i), ramp_exp[i], $sformatf("ramp%0d", i));
            end
        end
        in_valid = 1'b0;

        // Saturation with alpha=-1.0
        cfg(7'd1, 16'h8000);
        push(0, 16'h8000, 16'h0000, "sat0");
        push(0, 16'h7FFF, 16'h7FFF, "sat1");
        push(0, 16'h0000, 16'h8001, "sat2");
        in_valid = 1'b0;

        // Flush while an output is stalled
        cfg(7'd3, 16'h7FFF);
        push(0, 16'd1000, 16'd0, "ms0");
        push(0, 16'd2000, 16'd0, "ms1");
        push(0, 16'd3000, 16'd0, "ms2");
        push(0, 16'd4000, 16'd1000, "ms3");
        in_valid  = 1'b1;
        in_data   = 32'd5000;
        out_ready = 1'b0;
        step();
        chk("ms_hold_ov", 32'(out_valid), 32'd1);
        chk("ms_hold_od", out_data, 32'd1000);
        chk("ms_hold_rdy", 32'(in_ready), 32'd0);
        cfg(7'd3, 16'h7FFF);
        push(0, 16'd7, 16'd0, "ms4");
        push(0, 16'd8, 16'd0, "ms5");
        push(0, 16'd9, 16'd0, "ms6");
        push(0, 16'd10, 16'd7, "ms7");
        in_valid = 1'b0;

        // cfg_delay=0 clamps to 1
        cfg(7'd0, 16'h7FFF);
        push(0, 16'd11, 16'd0, "dz0");
        push(0, 16'd22, 16'd11, "dz1");
        chk("dz_primed", 32'(primed), 32'd1);
        in_valid = 1'b0;

        // cfg_delay=100 clamps to 64; random traffic with backpressure
        cfg(7'd100, 16'h7FFF);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_data   = {rnd16(), rnd16()};
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                exp_v = (got < 64) ? 32'd0 : in_q[got - 64];
                chk($sformatf("rand%0d", got), out_data, exp_v);
                got++;
            end
            if (in_valid && in_ready) begin
                in_q.push_back(in_data);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        chk("rand_cnt", 32'(got), 32'd200);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset mid-stream restores defaults
        cfg(7'd1, 16'h8000);
        push(0, 16'd50, 16'd0, "rm0");
        push(0, 16'd60, 16'hFFCE, "rm1");
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rm_ov", 32'(out_valid), 32'd0);
        chk("rm_od", out_data, 32'd0);
        chk("rm_primed", 32'(primed), 32'd0);
        push(0, 16'd5, 16'd0, "rm2");
        push(0, 16'd6, 16'd5, "rm3");
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
